// File: rtl/alu_pkg.sv
// Shared opcode encodings, writeback classes and FSM states for the ALU writeback stage.
// Build option ALU_WB_BYPASS_EN (see alu_regfile / alu_writeback) enables read-after-write forwarding.
package alu_pkg;

   localparam int REG_AW = 3;
   localparam int DATA_W = 16;
   localparam int STAT_W = 8;
   localparam int STK_W  = 12;

   // Named opcodes that the stage treats specially.
   localparam logic [5:0] OP_ADD = 6'h11;
   localparam logic [5:0] OP_MUL = 6'h21;
   localparam logic [5:0] OP_RTN = 6'h26;
   localparam logic [5:0] OP_GHS = 6'h16;

   // Register-writing encodings, as single codes and inclusive ranges.
   localparam logic [5:0] OP_WR_03    = 6'h03;
   localparam logic [5:0] OP_WR_A_LO  = 6'h06;
   localparam logic [5:0] OP_WR_A_HI  = 6'h09;
   localparam logic [5:0] OP_WR_B_LO  = 6'h0B;
   localparam logic [5:0] OP_WR_B_HI  = 6'h14;
   localparam logic [5:0] OP_WR_18    = 6'h18;
   localparam logic [5:0] OP_WR_19    = 6'h19;
   localparam logic [5:0] OP_WR_1B    = 6'h1B;
   localparam logic [5:0] OP_WR_C_LO  = 6'h1D;
   localparam logic [5:0] OP_WR_C_HI  = 6'h20;
   localparam logic [5:0] OP_WR_22    = 6'h22;

   // Status-only encodings.
   localparam logic [5:0] OP_GHOST_LO = 6'h15;
   localparam logic [5:0] OP_GHOST_HI = 6'h16;
   localparam logic [5:0] OP_FLAG_LO  = 6'h29;
   localparam logic [5:0] OP_FLAG_HI  = 6'h36;

   typedef enum logic [2:0] {WR_RD, GHOST, FLAG, MUL, STACK, NONE} wb_class_t;
   typedef enum logic {IDLE, WR_HI} wb_state_t;

   function automatic wb_class_t opcode_to_class(input logic [5:0] op);
      wb_class_t c;
      c = NONE;
      if (op inside {OP_WR_03, [OP_WR_A_LO:OP_WR_A_HI], [OP_WR_B_LO:OP_WR_B_HI],
                     OP_WR_18, OP_WR_19, OP_WR_1B, [OP_WR_C_LO:OP_WR_C_HI], OP_WR_22})
         c = WR_RD;
      else if (op inside {[OP_GHOST_LO:OP_GHOST_HI]})
         c = GHOST;
      else if (op inside {[OP_FLAG_LO:OP_FLAG_HI]})
         c = FLAG;
      else if (op == OP_MUL)
         c = MUL;
      else if (op == OP_RTN)
         c = STACK;
      return c;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 general register file: one synchronous write port, two combinational read ports.
// With ALU_WB_BYPASS_EN defined, reads of the register being written return the write data.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int REG_COUNT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   output logic [DATA_W-1:0] rs1_data_o,
   output logic [DATA_W-1:0] rs2_data_o
);

   logic [DATA_W-1:0] regs_q [REG_COUNT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

`ifdef ALU_WB_BYPASS_EN
   assign rs1_data_o = (we_i && (waddr_i == rs1_addr_i)) ? wdata_i : regs_q[rs1_addr_i];
   assign rs2_data_o = (we_i && (waddr_i == rs2_addr_i)) ? wdata_i : regs_q[rs2_addr_i];
`else
   assign rs1_data_o = regs_q[rs1_addr_i];
   assign rs2_data_o = regs_q[rs2_addr_i];
`endif

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: register file, status and stack registers, two-cycle MUL writeback FSM.
// ALU_WB_BYPASS_EN forwards in-flight register and status writes to the read side.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int               REG_COUNT = 8,
   parameter logic [STK_W-1:0] SP_RESET  = 12'hFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exec1,
   output logic              ready,
   input  logic [5:0]        encoded_opcode,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [DATA_W-1:0] aluout1,
   input  logic [DATA_W-1:0] aluout2,
   input  logic [STAT_W-1:0] statusregout,
   input  logic [STK_W-1:0]  decremented_stack_reg,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1data,
   output logic [DATA_W-1:0] rs2data,
   output logic [STAT_W-1:0] statusregin,
   output logic [STK_W-1:0]  stack_reg
);

   wb_state_t         state_q, state_d;
   logic [DATA_W-1:0] hi_data_q, hi_data_d;
   logic [REG_AW-1:0] hi_addr_q, hi_addr_d;
   logic [STAT_W-1:0] status_q, status_d;
   logic [STK_W-1:0]  stack_q, stack_d;

   wb_class_t         cls;
   logic              accept;
   logic              status_we;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   assign ready  = (state_q == IDLE);
   assign accept = exec1 & ready;
   assign cls    = opcode_to_class(encoded_opcode);

   assign status_we = accept & (cls inside {WR_RD, GHOST, FLAG, MUL});

   // The WR_HI cycle owns the write port; new work is not accepted then.
   assign rf_we    = ~reset & ((state_q == WR_HI) | (accept & (cls inside {WR_RD, MUL})));
   assign rf_waddr = (state_q == WR_HI) ? hi_addr_q : rd_addr;
   assign rf_wdata = (state_q == WR_HI) ? hi_data_q : aluout1;

   always_comb begin
      state_d   = state_q;
      hi_data_d = hi_data_q;
      hi_addr_d = hi_addr_q;
      status_d  = status_q;
      stack_d   = stack_q;
      if (state_q == WR_HI) state_d = IDLE;
      if (status_we) status_d = statusregout;
      if (accept && cls == STACK) stack_d = decremented_stack_reg;
      if (accept && cls == MUL) begin
         state_d   = WR_HI;
         hi_data_d = aluout2;
         hi_addr_d = rd_addr + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         hi_data_q <= '0;
         hi_addr_q <= '0;
         status_q  <= '0;
         stack_q   <= SP_RESET;
      end else begin
         state_q   <= state_d;
         hi_data_q <= hi_data_d;
         hi_addr_q <= hi_addr_d;
         status_q  <= status_d;
         stack_q   <= stack_d;
      end
   end

   alu_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .we_i       (rf_we),
      .waddr_i    (rf_waddr),
      .wdata_i    (rf_wdata),
      .rs1_addr_i (rs1_addr),
      .rs2_addr_i (rs2_addr),
      .rs1_data_o (rs1data),
      .rs2_data_o (rs2data)
   );

`ifdef ALU_WB_BYPASS_EN
   assign statusregin = (status_we && !reset) ? statusregout : status_q;
`else
   assign statusregin = status_q;
`endif
   assign stack_reg = stack_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        exec1;
  logic        ready;
  logic [5:0]  encoded_opcode;
  logic [2:0]  rd_addr;
  logic [15:0] aluout1, aluout2;
  logic [7:0]  statusregout;
  logic [11:0] decremented_stack_reg;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [15:0] rs1data, rs2data;
  logic [7:0]  statusregin;
  logic [11:0] stack_reg;

  localparam int K_RS1 = 0, K_RS2 = 1, K_STAT = 2, K_STK = 3, K_RDY = 4;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 clk = ~clk;

  alu_writeback #(.REG_COUNT(8), .SP_RESET(12'hFFF)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .exec1                 (exec1),
    .ready                 (ready),
    .encoded_opcode        (encoded_opcode),
    .rd_addr               (rd_addr),
    .aluout1               (aluout1),
    .aluout2               (aluout2),
    .statusregout          (statusregout),
    .decremented_stack_reg (decremented_stack_reg),
    .rs1_addr              (rs1_addr),
    .rs2_addr              (rs2_addr),
    .rs1data               (rs1data),
    .rs2data               (rs2data),
    .statusregin           (statusregin),
    .stack_reg             (stack_reg)
  );

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_t         e;
      logic [15:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RS1:   act = rs1data;
        K_RS2:   act = rs2data;
        K_STAT:  act = {8'h00, statusregin};
        K_STK:   act = {4'h0, stack_reg};
        default: act = {15'h0, ready};
      endcase
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
    end
  end

  task automatic expect_v(input int kind, input logic [15:0] exp, input string tag);
    sb_t e;
    e.kind = kind;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [7:0] st, input logic [11:0] sp);
    exec1                 = 1'b1;
    encoded_opcode        = op;
    rd_addr               = rd;
    aluout1               = a1;
    aluout2               = a2;
    statusregout          = st;
    decremented_stack_reg = sp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; exec1 = 1'b0; encoded_opcode = 6'h00; rd_addr = 3'd0;
    aluout1 = '0; aluout2 = '0; statusregout = '0; decremented_stack_reg = '0;
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    tick(); tick();
    reset = 1'b0;

    expect_v(K_STAT, 16'h0000, "reset_status");
    expect_v(K_STK,  16'h0FFF, "reset_stack");
    expect_v(K_RDY,  16'h0001, "reset_ready");
    for (int r = 0; r < 8; r++) begin
      rs1_addr = 3'(r);
      rs2_addr = 3'(7 - r);
      expect_v(K_RS1, 16'h0000, "reset_rs1");
      expect_v(K_RS2, 16'h0000, "reset_rs2");
      tick();
    end

    issue(6'h11, 3'd3, 16'h1234, 16'h0000, 8'h42, 12'h000);
    tick();
    exec1 = 1'b0; rs1_addr = 3'd3;
    expect_v(K_RS1,  16'h1234, "add_r3");
    expect_v(K_STAT, 16'h0042, "add_status");
    tick();

    issue(6'h21, 3'd7, 16'hBEEF, 16'h00CA, 8'h11, 12'h000);
    expect_v(K_RDY, 16'h0001, "mul_ready_c0");
    tick();
    issue(6'h11, 3'd1, 16'hDEAD, 16'h0000, 8'hEE, 12'h000);
    rs1_addr = 3'd7; rs2_addr = 3'd0;
    expect_v(K_RDY,  16'h0000, "mul_ready_whi");
    expect_v(K_RS1,  16'hBEEF, "mul_lo_r7");
`ifdef ALU_WB_BYPASS_EN
    expect_v(K_RS2,  16'h00CA, "mul_hi_r0_byp");
`else
    expect_v(K_RS2,  16'h0000, "mul_hi_r0_old");
`endif
    expect_v(K_STAT, 16'h0011, "mul_status");
    tick();
    exec1 = 1'b0;
    expect_v(K_RDY,  16'h0001, "mul_ready_back");
    expect_v(K_RS2,  16'h00CA, "mul_hi_r0");
    expect_v(K_STAT, 16'h0011, "whi_pulse_status");
    rs1_addr = 3'd1;
    expect_v(K_RS1,  16'h0000, "whi_pulse_r1");
    tick();

    issue(6'h21, 3'd2, 16'h1111, 16'h2222, 8'h99, 12'h000);
    tick();
    exec1 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; rs1_addr = 3'd3; rs2_addr = 3'd2;
    expect_v(K_RDY,  16'h0001, "rst_whi_ready");
    expect_v(K_RS1,  16'h0000, "rst_whi_r3");
    expect_v(K_RS2,  16'h0000, "rst_whi_r2");
    expect_v(K_STAT, 16'h0000, "rst_whi_status");
    expect_v(K_STK,  16'h0FFF, "rst_whi_stack");
    tick();

    issue(6'h26, 3'd4, 16'h4444, 16'h0000, 8'h77, 12'hFFE);
    tick();
    exec1 = 1'b0; rs1_addr = 3'd4;
    expect_v(K_STK,  16'h0FFE, "rtn_stack");
    expect_v(K_STAT, 16'h0000, "rtn_status");
    expect_v(K_RS1,  16'h0000, "rtn_r4");
    tick();

    issue(6'h16, 3'd5, 16'h5555, 16'h0000, 8'h80, 12'h123);
    tick();
    exec1 = 1'b0; rs1_addr = 3'd5;
    expect_v(K_STAT, 16'h0080, "ghs_status");
    expect_v(K_RS1,  16'h0000, "ghs_r5");
    expect_v(K_STK,  16'h0FFE, "ghs_stack");
    tick();

    issue(6'h2A, 3'd6, 16'h6666, 16'h0000, 8'h3C, 12'h000);
    tick();
    exec1 = 1'b0; rs1_addr = 3'd6;
    expect_v(K_STAT, 16'h003C, "flag_status");
    expect_v(K_RS1,  16'h0000, "flag_r6");
    tick();
    issue(6'h00, 3'd6, 16'h7777, 16'h0000, 8'hFF, 12'h000);
    tick();
    exec1 = 1'b0;
    expect_v(K_STAT, 16'h003C, "none_status");
    expect_v(K_RS1,  16'h0000, "none_r6");
    tick();

    issue(6'h03, 3'd5, 16'hA5A5, 16'h0000, 8'h5A, 12'h000);
    rs2_addr = 3'd5;
`ifdef ALU_WB_BYPASS_EN
    expect_v(K_RS2,  16'hA5A5, "raw_same_cycle_byp");
    expect_v(K_STAT, 16'h005A, "raw_status_byp");
`else
    expect_v(K_RS2,  16'h0000, "raw_same_cycle_old");
    expect_v(K_STAT, 16'h003C, "raw_status_old");
`endif
    tick();
    exec1 = 1'b0;
    expect_v(K_RS2,  16'hA5A5, "raw_next_cycle");
    expect_v(K_STAT, 16'h005A, "raw_status_next");
    tick();

    issue(6'h22, 3'd0, 16'h0F0F, 16'h0000, 8'h01, 12'h000);
    tick();
    exec1 = 1'b0; rs1_addr = 3'd0;
    expect_v(K_RS1,  16'h0F0F, "op22_r0");
    expect_v(K_STAT, 16'h0001, "op22_status");
    tick();
    @(negedge clk);
    #1;

    n_checks++;
    if (rs1data === 16'h0F0F) n_pass++;
    else $display("FAIL final_r0: got %h expected %h", rs1data, 16'h0F0F);
    n_checks++;
    if (statusregin === 8'h01) n_pass++;
    else $display("FAIL final_status: got %h expected %h", statusregin, 8'h01);
    n_checks++;
    if (stack_reg === 12'hFFE) n_pass++;
    else $display("FAIL final_stack: got %h expected %h", stack_reg, 12'hFFE);
    n_checks++;
    if (ready === 1'b1) n_pass++;
    else $display("FAIL final_ready: got %b expected %b", ready, 1'b1);
    n_checks++;
    if (rs2data === 16'hA5A5) n_pass++;
    else $display("FAIL final_r5: got %h expected %h", rs2data, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass != n_checks) $display("FAIL summary: got %0d expected %0d", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the ALU; consumes ALU results, status and stack outputs on the exec1 strobe.
- Owns the 8x16 general register file and feeds rs1data/rs2data back to the ALU through two combinational read ports.
- Owns the 8-bit status register (fed back as statusregin) and the 12-bit stack register (fed back as stack_reg).
- MUL writes back over two cycles and stalls the pipeline.

Parameters:
- REG_COUNT, 8, number of general registers (address width fixed at 3)
- SP_RESET, 12'hFFF, stack register value after reset

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- exec1  in  1  valid strobe: ALU outputs and opcode are valid this cycle
- ready  out  1  stage can accept exec1; low during the MUL high-half cycle
- encoded_opcode  in  6  opcode of the instruction in the ALU
- rd_addr  in  3  destination register
- aluout1  in  16  primary ALU result (MUL low half)
- aluout2  in  16  MUL high half
- statusregout  in  8  next status value from the ALU
- decremented_stack_reg  in  12  next stack value from the ALU (RTN)
- rs1_addr, rs2_addr  in  3 each  read-port addresses
- rs1data, rs2data  out  16 each  read-port data
- statusregin  out  8  current status register
- stack_reg  out  12  current stack register

Behaviour:
- Accept = exec1 & ready. With exec1 high and ready low, the input is ignored; upstream holds it until ready returns.
- Opcodes are classified on accept:
  - WR_RD: 03, 06–09, 0B–14, 18, 19, 1B, 1D–20, 22.
    - Next edge: R[rd_addr] <= aluout1 and status <= statusregout.
  - GHOST: 15, 16.
    - Status <= statusregout; no register write.
  - FLAG: 29–36.
    - Status <= statusregout only.
  - MUL: 21.
    - Cycle 0 edge: R[rd] <= aluout1, status <= statusregout, state -> WR_HI, and hi data and (rd+1) mod 8 are latched internally.
    - Cycle 1 edge: R[(rd+1) mod 8] <= latched hi, state -> IDLE.
    - rd = 7 wraps the high half into R0.
  - STACK: 26 (RTN).
    - stack_reg <= decremented_stack_reg; no register or status write.
  - NONE: all other opcodes. No state change.
- FSM has states IDLE and WR_HI.
  - ready = (state == IDLE).
  - WR_HI always returns to IDLE after exactly one cycle; exec1 in WR_HI is ignored.
- Read ports are combinational from the register array.
  - A read of a register being written on the same edge returns the old value (see optional feature).
- Write latency is one edge: a result accepted in cycle N is visible on the read ports in cycle N+1.
- R0 is an ordinary register (not hardwired).
- Reset:
  - All registers = 16'h0000, statusregin = 8'h00, stack_reg = SP_RESET, state = IDLE, ready = 1.
  - Reset asserted in WR_HI aborts the high-half write; reset wins over any coincident accept.
- Widths are exact and there is no arithmetic in this block; the (rd+1) address wraps modulo 8.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- Defined: each read port compares its address against the active write port (the accepted WR_RD/MUL low write, or the WR_HI write). On a match it returns the data being written, giving zero-cycle read-after-write. statusregin is likewise bypassed from statusregout on an accepted status-writing op.
- Undefined: no forwarding; old value returned as described above.

Decomposition:
- Shared package alu_pkg:
  - 6-bit opcode localparams for all encodings listed above
  - wb_class_t enum {WR_RD, GHOST, FLAG, MUL, STACK, NONE}
  - wb_state_t enum {IDLE, WR_HI}
  - function opcode_to_class
- One sub-module, alu_regfile: 8x16 array with one write port, two combinational read ports, and the optional bypass.
- The FSM, status register and stack register stay in the top-level module.

Test Plan:
- Reset, then read all 8 registers -> every read 16'h0000, statusregin = 8'h00, stack_reg = 12'hFFF, ready = 1.
- Accept ADD (11), rd = 3, aluout1 = 16'h1234, statusregout = 8'h42 -> next cycle rs1_addr = 3 reads 16'h1234, statusregin = 8'h42.
- Accept MUL (21), rd = 7, aluout1 = 16'hBEEF, aluout2 = 16'h00CA:
  - ready = 0 for one cycle
  - R7 = 16'hBEEF, R0 = 16'h00CA
  - an exec1 pulse during WR_HI changes nothing
- Reset asserted during WR_HI of a MUL, rd = 2 -> R3 stays 16'h0000 and ready = 1 the next cycle.
- Accept RTN (26), decremented_stack_reg = 12'hFFE -> stack_reg = 12'hFFE; registers and status are unchanged. Then GHS (16) with statusregout = 8'h80 -> status = 8'h80 and no register changes.
- Write R5 = 16'hA5A5 while reading rs2_addr = 5 in the same cycle:
  - without ALU_WB_BYPASS_EN -> old value, then 16'hA5A5 next cycle
  - with ALU_WB_BYPASS_EN -> 16'hA5A5 in the same cycle
